rgb_led_sequencer: RTL and testbench

- Downstream consumer of the on-board blinky's toggling LED register (1 Hz-class square wave on `clk`).
- Turns that signal into a colour-cycling, fade-in PWM drive for the red/green/blue LEDs.
- Each rising edge of `blink_in` advances the colour and restarts a linear brightness ramp.
- Lives in the FPGA fabric on the same `clk` as the blinky; outputs go straight to LED pads.

---
 rtl/rgb_led_sequencer.sv | 149 ++++++++++++++
 tb/tb_rgb_led_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/rgb_led_sequencer.sv
// Colour-cycling fade-in PWM drive for RGB LEDs; each rising edge of blink_in advances the colour.
// Optional: define LED_ACTIVE_LOW_EN to invert the three LED drives for common-anode boards.
module rgb_led_sequencer #(
    parameter int PWM_BITS  = 8,
    parameter int MAX_LEVEL = 200,
    parameter int FADE_DIV  = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       blink_in,
    input  logic       enable,
    output logic       redled,
    output logic       greenled,
    output logic       blueled,
    output logic [1:0] colour,
    output logic       holding,
    output logic [1:0] dbg_state
);

    localparam int DIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(FADE_DIV - 1);
    localparam logic [PWM_BITS-1:0] LEVEL_MAX = PWM_BITS'(MAX_LEVEL);

`ifdef LED_ACTIVE_LOW_EN
    localparam logic LED_INV = 1'b1;
`else
    localparam logic LED_INV = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_OFF     = 2'd0,
        S_FADE_IN = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t              r_state;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [DIV_W-1:0]    r_div_cnt;
    logic [PWM_BITS-1:0] r_level;
    logic [1:0]          r_colour;
    logic                r_blink_q;
    logic                r_holding;
    logic                r_red;
    logic                r_green;
    logic                r_blue;

    state_t              w_next_state;
    logic [DIV_W-1:0]    w_next_div;
    logic [PWM_BITS-1:0] w_next_level;
    logic [1:0]          w_next_colour;
    logic                w_rise;
    logic                w_fade_tick;
    logic                w_on;

    assign w_rise      = blink_in & ~r_blink_q;
    assign w_fade_tick = (r_div_cnt == DIV_LAST);
    assign w_on        = (r_pwm_cnt < r_level);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_OFF;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Priority: enable low, then colour advance on rise, then fade step.
    always_comb begin
        w_next_state  = r_state;
        w_next_level  = r_level;
        w_next_colour = r_colour;
        w_next_div    = w_fade_tick ? '0 : r_div_cnt + 1'b1;
        if (!enable) begin
            w_next_state  = S_OFF;
            w_next_level  = '0;
            w_next_colour = 2'd0;
            w_next_div    = '0;
        end else begin
            case (r_state)
                S_OFF: begin
                    w_next_state  = S_FADE_IN;
                    w_next_level  = '0;
                    w_next_colour = 2'd0;
                    w_next_div    = '0;
                end
                S_FADE_IN, S_HOLD: begin
                    if (w_rise) begin
                        w_next_state  = S_FADE_IN;
                        w_next_colour = r_colour + 2'd1;
                        w_next_level  = '0;
                        w_next_div    = '0;
                    end else if (r_state == S_FADE_IN && w_fade_tick) begin
                        if (r_level >= LEVEL_MAX - 1'b1) begin
                            w_next_level = LEVEL_MAX;
                            w_next_state = S_HOLD;
                        end else begin
                            w_next_level = r_level + 1'b1;
                        end
                    end
                end
                default: begin
                    w_next_state  = S_OFF;
                    w_next_level  = '0;
                    w_next_colour = 2'd0;
                    w_next_div    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= '0;
            r_div_cnt <= '0;
            r_level   <= '0;
            r_colour  <= 2'd0;
            r_blink_q <= 1'b0;
            r_holding <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_div_cnt <= w_next_div;
            r_level   <= w_next_level;
            r_colour  <= w_next_colour;
            r_blink_q <= blink_in;
            r_holding <= (w_next_state == S_HOLD);
        end
    end

    // LED drives sample the current level/colour, so they trail the state by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_red   <= LED_INV;
            r_green <= LED_INV;
            r_blue  <= LED_INV;
        end else begin
            r_red   <= (w_on & ((r_colour == 2'd0) | (r_colour == 2'd3))) ^ LED_INV;
            r_green <= (w_on & ((r_colour == 2'd1) | (r_colour == 2'd3))) ^ LED_INV;
            r_blue  <= (w_on & ((r_colour == 2'd2) | (r_colour == 2'd3))) ^ LED_INV;
        end
    end

    assign redled    = r_red;
    assign greenled  = r_green;
    assign blueled   = r_blue;
    assign colour    = r_colour;
    assign holding   = r_holding;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Directed bench for rgb_led_sequencer (PWM_BITS=4, MAX_LEVEL=8, FADE_DIV=2); cycle-tagged expectations
// are queued by the stimulus and popped by a monitor on the falling edge.
module tb_rgb_led_sequencer;

    localparam int PWM_BITS  = 4;
    localparam int MAX_LEVEL = 8;
    localparam int FADE_DIV  = 2;
    localparam int W         = 28;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic [2:0] LED_INV = 3'b111;
`else
    localparam logic [2:0] LED_INV = 3'b000;
`endif

    // Mask over {red, green, blue, colour[1:0], holding}.
    localparam logic [5:0] M_ALL = 6'h3f;
    localparam logic [5:0] M_CH  = 6'h07;
    localparam logic [5:0] M_H   = 6'h01;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       blink_in = 1'b1;
    logic       enable   = 1'b1;
    logic       redled;
    logic       greenled;
    logic       blueled;
    logic [1:0] colour;
    logic       holding;
    logic [1:0] dbg_state;

    logic       run   = 1'b0;
    int         cyc   = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [W-1:0] exp_q[$];

    rgb_led_sequencer #(
        .PWM_BITS  (PWM_BITS),
        .MAX_LEVEL (MAX_LEVEL),
        .FADE_DIV  (FADE_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .blink_in  (blink_in),
        .enable    (enable),
        .redled    (redled),
        .greenled  (greenled),
        .blueled   (blueled),
        .colour    (colour),
        .holding   (holding),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (run) cyc <= cyc + 1;
    end

    // ---------------- expectation helpers ----------------
    function automatic logic [2:0] col_leds(input logic [1:0] c, input logic on);
        case (c)
            2'd0:    col_leds = {on, 1'b0, 1'b0};
            2'd1:    col_leds = {1'b0, on, 1'b0};
            2'd2:    col_leds = {2'b00, on};
            default: col_leds = {on, on, on};
        endcase
    endfunction

    function automatic void push(input int n, input logic [5:0] m, input logic [2:0] leds,
                                 input logic [1:0] c, input logic h);
        exp_q.push_back({16'(n), m, leds ^ LED_INV, c, h});
    endfunction

    function automatic logic is_blink(input int n);
        return n inside {1, 40, 41, 80, 81, 120, 121, 160, 161, 164, 165, 200, 201, 203, 204};
    endfunction

    // Hand-derived expectations for the sample taken after rising edge n.
    function automatic void queue_checks(input int n);
        int r;
        // first fade from reset release: level = (n-1)/2, HOLD at edge 17
        if (n == 1)  push(n, M_ALL, 3'b000, 2'd0, 1'b0);
        if (n == 16) push(n, M_ALL, 3'b000, 2'd0, 1'b0);
        if (n == 17) push(n, M_ALL, 3'b100, 2'd0, 1'b1);
        if (n >= 18 && n <= 33) push(n, M_ALL, col_leds(2'd0, ((n - 1) % 16) < 8), 2'd0, 1'b1);
        // colour advances at edges 40, 80, 120, 160
        for (int k = 0; k < 4; k++) begin
            r = 40 + 40 * k;
            if (n == r - 1) push(n, M_ALL, col_leds(2'(k), ((r - 2) % 16) < 8), 2'(k), 1'b1);
            if (n == r)     push(n, M_CH, 3'b000, 2'(k + 1), 1'b0);
            if (n == r + 1) push(n, M_ALL, 3'b000, 2'(k + 1), 1'b0);
            if (k < 3) begin
                if (n == r + 15) push(n, M_H, 3'b000, 2'd0, 1'b0);
                if (n == r + 16) push(n, M_CH, 3'b000, 2'(k + 1), 1'b1);
                if (n >= r + 20 && n <= r + 35)
                    push(n, M_ALL, col_leds(2'(k + 1), ((n - 1) % 16) < 8), 2'(k + 1), 1'b1);
            end
        end
        // rise coincident with fade_tick at edge 164
        if (n == 163) push(n, M_CH, 3'b000, 2'd0, 1'b0);
        if (n == 164) push(n, M_CH, 3'b000, 2'd1, 1'b0);
        if (n == 165) push(n, M_ALL, 3'b000, 2'd1, 1'b0);
        if (n == 179) push(n, M_H, 3'b000, 2'd0, 1'b0);
        if (n == 180) push(n, M_CH, 3'b000, 2'd1, 1'b1);
        // enable dropped together with a rise at edge 200, rise in OFF at 203
        if (n == 199) push(n, M_ALL, 3'b010, 2'd1, 1'b1);
        if (n == 200) push(n, M_ALL, 3'b010, 2'd0, 1'b0);
        if (n == 201) push(n, M_ALL, 3'b000, 2'd0, 1'b0);
        if (n == 204) push(n, M_ALL, 3'b000, 2'd0, 1'b0);
        // re-enabled at 214, level 5 by 225, async reset just after edge 226
        if (n == 225) push(n, M_ALL, 3'b100, 2'd0, 1'b0);
        if (n >= 226 && n <= 229) push(n, M_ALL, 3'b000, 2'd0, 1'b0);
        if (n == 245) push(n, M_ALL, 3'b000, 2'd0, 1'b0);
        if (n == 246) push(n, M_ALL, 3'b100, 2'd0, 1'b1);
        if (n >= 250 && n <= 265) push(n, M_ALL, col_leds(2'd0, ((n - 230) % 16) < 8), 2'd0, 1'b1);
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : monitor
        logic [5:0]   act;
        logic [W-1:0] e;
        act = {redled, greenled, blueled, colour, holding};
        while (exp_q.size() > 0 && int'(exp_q[0][27:12]) <= cyc) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (int'(e[27:12]) != cyc) begin
                n_bad++;
                $display("FAIL missed_check tag=%0d actual_cycle=%0d required_cycle=%0d",
                         e[27:12], cyc, e[27:12]);
            end else if ((act & e[11:6]) !== (e[5:0] & e[11:6])) begin
                n_bad++;
                $display("FAIL cyc%0d_outputs rgb/col/hold actual=%b required=%b mask=%b state=%0d",
                         cyc, act, e[5:0], e[11:6], dbg_state);
            end
        end
    end

    // ---------------- driver ----------------
    initial begin
        push(0, M_ALL, 3'b000, 2'd0, 1'b0);
        repeat (2) @(posedge clk);
        #7;
        for (int n = 1; n <= 270; n++) begin
            rst      = (n >= 227 && n <= 229);
            enable   = !(n >= 200 && n <= 213);
            blink_in = is_blink(n);
            run      = 1'b1;
            queue_checks(n);
            @(posedge clk);
            #2;
        end
        repeat (2) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_checks actual=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
